fetch_decode: RTL
=================

// Module: fetch_decode
// PURPOSE
//  Control front end of the 8-bit core: reads instruction bytes from instruction memory at the
//  current pc and turns them into per-instruction control for the datapath (rd, rs, imm, alu_op,
//  alu_ex, reg_wr, pc_src, rimm, alu_src, mem_to_reg). Fetches variable-length instructions
//  (1 byte, or 2 with an immediate) over multiple cycles. Emits a one-cycle step strobe that gates
//  pc/register commit in the datapath.
// PARAMETERS
//  IMEM_LAT  1     instruction-memory read latency in cycles (1..3); data valid IMEM_LAT cycles after imem_rd
//  HALT_OP   4'hF  opcode that stops fetching until reset
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  pc            in   8      current program counter from datapath
//  alu_zero      in   1      datapath ALU zero flag (conditional branch)
//  imem_rd       out  1      instruction-memory read request
//  imem_addr     out  8      instruction-memory byte address
//  imem_rd_data  in   8      instruction-memory read data
//  step          out  1      one-cycle strobe: controls valid, datapath commits pc/regfile/mem this cycle
//  rd, rs        out  e_reg  destination / source register fields
//  imm           out  word   immediate byte (0 for 1-byte instructions)
//  alu_op        out  e_alu_op      ALU operation
//  alu_ex        out  e_alu_ext_op  ALU extended operation (ALU_EX_NONE unless opcode uses it)
//  reg_wr, mem_wr, mem_to_reg, alu_src, pc_src, rimm   out 1 each   datapath controls
//  halted        out  1      HALT_OP executed; sticky until rst
//  illegal       out  1      undefined opcode seen; sticky until rst (executed as NOP)
// BEHAVIOUR
//  Encoding: byte0 = {opcode[7:4], rd[3:2], rs[1:0]}; rimm opcodes followed by imm byte at pc+1.
//  Opcodes: 0 NOP, 1 MOV(ALU_CPY), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LDI*, 8 LD, 9 ST, A JMP*,
//   B BEQ*(SUB, pc_src=alu_zero, no reg_wr), C ADDI*; D,E undefined; F HALT. (* = rimm, 2 bytes)
//  Reset: state S_FETCH, all outputs 0 (rd/rs=ra, alu_op=ALU_CPY, imem_rd=0); halted/illegal cleared.
//  FSM:
//   S_FETCH: imem_addr=pc, imem_rd=1 for one cycle -> S_WOP.
//   S_WOP:   wait IMEM_LAT-1 further cycles (counter), capture byte0 when valid; rimm op ->
//            issue imem_addr=pc+1 (8-bit wrap, 8'hFF+1=8'h00), -> S_WIMM; else -> S_EXEC.
//   S_WIMM:  wait IMEM_LAT cycles, capture imm -> S_EXEC.
//   S_EXEC:  step=1 and decoded controls asserted this cycle only -> S_FETCH; HALT_OP -> S_HALT.
//   S_HALT:  step=0, imem_rd=0, halted=1; leave only via rst.
//  Latency (IMEM_LAT=1): 1-byte instr 3 cycles, 2-byte instr 4 cycles, fetch-to-fetch.
//  reg_wr, mem_wr, pc_src only ever high while step=1; rd/rs/imm/alu_op held stable from capture
//   until next capture. pc input sampled in S_FETCH and S_WOP only; must be stable otherwise.
//  rimm=1 in S_EXEC for 2-byte instrs so datapath advances pc by 2; JMP: pc_src=1; BEQ: pc_src=alu_zero
//   sampled in S_EXEC. LD: alu_src=1 addr=imm? no: LD/ST use rs as address, mem_to_reg=1 (LD), mem_wr=1 (ST).
//  Undefined opcode: illegal set in S_EXEC, no write/branch enables, step=1 (pc advances by 1).
//  rst mid-instruction: abandons fetch, returns to S_FETCH next cycle, outstanding read data ignored.
// STRUCTURE
//  project_pkg: e_opcode enum (16 values), OPC_* constants, e_fd_state enum, function needs_imm(e_opcode).
//  Sub-module: instr_decoder (combinational byte0 -> control struct), instantiated once; FSM,
//   latency counter and capture registers in fetch_decode.
// TESTING
//  1 Reset: rst high 2 cycles, imem returns 8'hFF -> all outputs 0, imem_rd=0, no step, halted=0.
//  2 ADD rb,rc (8'h26) at pc=0, IMEM_LAT=1 -> step on cycle 3, alu_op=ALU_ADD, rd=rb, rs=rc,
//    reg_wr=1, rimm=0, imm=0; imem_addr=0 once.
//  3 LDI ra,8'h7A (8'h70,8'h7A) at pc=8'hFF -> second read at addr 8'h00, step on cycle 4,
//    imm=8'h7A, alu_src=1, rimm=1, reg_wr=1.
//  4 BEQ (8'hB1, 8'h40) with alu_zero=1 then 0 -> pc_src=1 then 0 during step; reg_wr=0 both.
//  5 Opcode 8'hD0 then 8'hF0 -> illegal=1, no enables, step once; then halted=1, imem_rd stays 0
//    for 20 cycles; rst clears both.
//  6 IMEM_LAT=3, rst asserted in S_WIMM -> back to S_FETCH, late data not captured, no step.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared types for the 8-bit core front end: opcodes, register names, ALU ops,
// fetch/decode FSM states and the decoded control bundle.
package fetch_decode_pkg;

  typedef logic [7:0] word;

  typedef enum logic [1:0] {
    RA = 2'd0,
    RB = 2'd1,
    RC = 2'd2,
    RD = 2'd3
  } e_reg;

  typedef enum logic [2:0] {
    ALU_CPY = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5
  } e_alu_op;

  // PASS_B routes operand B (the immediate) straight to the result for LDI.
  typedef enum logic [1:0] {
    ALU_EX_NONE   = 2'd0,
    ALU_EX_PASS_B = 2'd1
  } e_alu_ext_op;

  typedef enum logic [3:0] {
    OPC_NOP   = 4'h0,
    OPC_MOV   = 4'h1,
    OPC_ADD   = 4'h2,
    OPC_SUB   = 4'h3,
    OPC_AND   = 4'h4,
    OPC_OR    = 4'h5,
    OPC_XOR   = 4'h6,
    OPC_LDI   = 4'h7,
    OPC_LD    = 4'h8,
    OPC_ST    = 4'h9,
    OPC_JMP   = 4'hA,
    OPC_BEQ   = 4'hB,
    OPC_ADDI  = 4'hC,
    OPC_UND_D = 4'hD,
    OPC_UND_E = 4'hE,
    OPC_HALT  = 4'hF
  } e_opcode;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WOP   = 3'd1,
    S_WIMM  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } e_fd_state;

  typedef struct packed {
    e_reg        rd;
    e_reg        rs;
    e_alu_op     alu_op;
    e_alu_ext_op alu_ex;
    logic        rimm;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        alu_src;
    logic        jmp;
    logic        beq;
    logic        halt;
    logic        illegal;
  } fd_ctrl_t;

  localparam int LAT_CNT_W = 2;

  function automatic logic needs_imm(e_opcode op);
    return (op == OPC_LDI) || (op == OPC_JMP) || (op == OPC_BEQ) || (op == OPC_ADDI);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode front end and the datapath / instruction memory.
interface fetch_decode_if;
  import fetch_decode_pkg::*;

  logic        pc_dummy_unused_guard;
  word         pc;
  logic        alu_zero;
  logic        imem_rd;
  word         imem_addr;
  word         imem_rd_data;
  logic        step;
  e_reg        rd;
  e_reg        rs;
  word         imm;
  e_alu_op     alu_op;
  e_alu_ext_op alu_ex;
  logic        reg_wr;
  logic        mem_wr;
  logic        mem_to_reg;
  logic        alu_src;
  logic        pc_src;
  logic        rimm;
  logic        halted;
  logic        illegal;

  modport master (
    input  pc, alu_zero, imem_rd_data,
    output imem_rd, imem_addr, step, rd, rs, imm, alu_op, alu_ex,
           reg_wr, mem_wr, mem_to_reg, alu_src, pc_src, rimm, halted, illegal
  );

  modport slave (
    output pc, alu_zero, imem_rd_data,
    input  imem_rd, imem_addr, step, rd, rs, imm, alu_op, alu_ex,
           reg_wr, mem_wr, mem_to_reg, alu_src, pc_src, rimm, halted, illegal
  );

endinterface

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational decode of the opcode byte into the control bundle.
module fetch_decode_instr_decoder
  import fetch_decode_pkg::*;
#(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  word      byte0,
  output fd_ctrl_t ctrl
);

  e_opcode op;
  assign op = e_opcode'(byte0[7:4]);

  always_comb begin
    ctrl        = '0;
    ctrl.rd     = e_reg'(byte0[3:2]);
    ctrl.rs     = e_reg'(byte0[1:0]);
    ctrl.alu_op = ALU_CPY;
    ctrl.alu_ex = ALU_EX_NONE;
    ctrl.rimm   = needs_imm(op);
    if (byte0[7:4] == HALT_OP) begin
      ctrl.halt = 1'b1;
    end else begin
      case (op)
        OPC_NOP: ;
        OPC_MOV: ctrl.reg_wr = 1'b1;
        OPC_ADD: begin
          ctrl.alu_op = ALU_ADD;
          ctrl.reg_wr = 1'b1;
        end
        OPC_SUB: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.reg_wr = 1'b1;
        end
        OPC_AND: begin
          ctrl.alu_op = ALU_AND;
          ctrl.reg_wr = 1'b1;
        end
        OPC_OR: begin
          ctrl.alu_op = ALU_OR;
          ctrl.reg_wr = 1'b1;
        end
        OPC_XOR: begin
          ctrl.alu_op = ALU_XOR;
          ctrl.reg_wr = 1'b1;
        end
        OPC_LDI: begin
          ctrl.alu_ex  = ALU_EX_PASS_B;
          ctrl.alu_src = 1'b1;
          ctrl.reg_wr  = 1'b1;
        end
        // Loads and stores address memory through rs, no immediate.
        OPC_LD: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_wr     = 1'b1;
        end
        OPC_ST:  ctrl.mem_wr = 1'b1;
        OPC_JMP: ctrl.jmp = 1'b1;
        OPC_BEQ: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.beq    = 1'b1;
        end
        OPC_ADDI: begin
          ctrl.alu_op  = ALU_ADD;
          ctrl.alu_src = 1'b1;
          ctrl.reg_wr  = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Multi-cycle fetch of 1/2-byte instructions and per-instruction control issue
// with a one-cycle step strobe that gates datapath commit.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int         IMEM_LAT = 1,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input logic             clk,
  input logic             rst,
  fetch_decode_if.master  bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(IMEM_LAT - 1);

  e_fd_state             state;
  logic [LAT_CNT_W-1:0]  cnt;
  logic                  data_ok;
  fd_ctrl_t              dec;

  logic        step_r;
  e_reg        rd_r;
  e_reg        rs_r;
  word         imm_r;
  e_alu_op     alu_op_r;
  e_alu_ext_op alu_ex_r;
  logic        rimm_r;
  logic        reg_wr_r;
  logic        mem_wr_r;
  logic        mem_to_reg_r;
  logic        alu_src_r;
  logic        jmp_r;
  logic        beq_r;
  logic        halt_r;
  logic        halted_r;
  logic        illegal_r;

  logic        imem_rd;
  word         imem_addr;

  fetch_decode_instr_decoder #(.HALT_OP(HALT_OP)) u_dec (
    .byte0 (bus.imem_rd_data),
    .ctrl  (dec)
  );

  // Read data for the outstanding request is valid on the last wait cycle.
  assign data_ok = (cnt == LAT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      cnt          <= '0;
      step_r       <= 1'b0;
      rd_r         <= RA;
      rs_r         <= RA;
      imm_r        <= '0;
      alu_op_r     <= ALU_CPY;
      alu_ex_r     <= ALU_EX_NONE;
      rimm_r       <= 1'b0;
      reg_wr_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_to_reg_r <= 1'b0;
      alu_src_r    <= 1'b0;
      jmp_r        <= 1'b0;
      beq_r        <= 1'b0;
      halt_r       <= 1'b0;
      halted_r     <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      step_r <= 1'b0;
      case (state)
        S_FETCH: begin
          cnt   <= '0;
          state <= S_WOP;
        end
        S_WOP: begin
          if (data_ok) begin
            cnt          <= '0;
            rd_r         <= dec.rd;
            rs_r         <= dec.rs;
            imm_r        <= '0;
            alu_op_r     <= dec.alu_op;
            alu_ex_r     <= dec.alu_ex;
            rimm_r       <= dec.rimm;
            reg_wr_r     <= dec.reg_wr;
            mem_wr_r     <= dec.mem_wr;
            mem_to_reg_r <= dec.mem_to_reg;
            alu_src_r    <= dec.alu_src;
            jmp_r        <= dec.jmp;
            beq_r        <= dec.beq;
            halt_r       <= dec.halt;
            if (dec.rimm) begin
              state <= S_WIMM;
            end else begin
              state  <= S_EXEC;
              step_r <= 1'b1;
              if (dec.illegal) illegal_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WIMM: begin
          if (data_ok) begin
            cnt    <= '0;
            imm_r  <= bus.imem_rd_data;
            state  <= S_EXEC;
            step_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (halt_r) begin
            state    <= S_HALT;
            halted_r <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // The immediate read is issued in the same cycle the opcode byte arrives.
  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = '0;
    if (!rst) begin
      if (state == S_FETCH) begin
        imem_rd   = 1'b1;
        imem_addr = bus.pc;
      end else if ((state == S_WOP) && data_ok && dec.rimm) begin
        imem_rd   = 1'b1;
        imem_addr = bus.pc + 8'd1;
      end
    end
  end

  assign bus.imem_rd    = imem_rd;
  assign bus.imem_addr  = imem_addr;
  assign bus.step       = step_r;
  assign bus.rd         = rd_r;
  assign bus.rs         = rs_r;
  assign bus.imm        = imm_r;
  assign bus.alu_op     = alu_op_r;
  assign bus.alu_ex     = alu_ex_r;
  assign bus.rimm       = step_r & rimm_r;
  assign bus.reg_wr     = step_r & reg_wr_r;
  assign bus.mem_wr     = step_r & mem_wr_r;
  assign bus.mem_to_reg = step_r & mem_to_reg_r;
  assign bus.alu_src    = step_r & alu_src_r;
  // BEQ resolves on the zero flag present during the commit cycle.
  assign bus.pc_src     = step_r & (jmp_r | (beq_r & bus.alu_zero));
  assign bus.halted     = halted_r;
  assign bus.illegal    = illegal_r;

endmodule
